// File: rtl/spram_ctrl_pkg.sv
// +-----------------------------------------------------------------+
// | spram_ctrl_pkg: FSM states and default geometry for spram_ctrl |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package spram_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spram_clear_seq.sv
// +-----------------------------------------------------------------+
// | spram_clear_seq: address counter for the post-reset RAM clear  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module spram_clear_seq #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter parks at DEPTH, which flags the sweep as finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (step_i && !done_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = (cnt_q == CNT_W'(DEPTH));
  assign addr_o = ADDR_W'(cnt_q);

endmodule

`default_nettype wire

// File: rtl/spram_ctrl.sv
// +-----------------------------------------------------------------+
// | spram_ctrl: request/response front end for a single-port RAM.  |
// | Optional post-reset clear sweep: define SPRAM_CTRL_CLEAR_EN.   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module spram_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy,
  output logic              ram_en,
  output logic              ram_wr_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

`ifdef SPRAM_CTRL_CLEAR_EN
  localparam state_e RST_STATE = ST_INIT;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e            st_q, st_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_wr_rd_q, ram_wr_rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic hs;
  logic in_range;

  assign hs       = req_valid && req_ready_q;
  assign in_range = ({1'b0, req_addr} < DEPTH_LIM);

`ifdef SPRAM_CTRL_CLEAR_EN
  logic              init_busy_q, init_busy_d;
  logic              seq_step;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_done;

  spram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk    (clk),
    .rst    (rst),
    .step_i (seq_step),
    .addr_o (seq_addr),
    .done_o (seq_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      init_busy_q <= 1'b0;
    end else begin
      init_busy_q <= init_busy_d;
    end
  end

  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up with st_q.
  always_comb begin
    st_d        = st_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_en_d    = 1'b0;
    ram_wr_rd_d = ram_wr_rd_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef SPRAM_CTRL_CLEAR_EN
    init_busy_d = 1'b0;
    seq_step    = 1'b0;
`endif
    case (st_q)
`ifdef SPRAM_CTRL_CLEAR_EN
      ST_INIT: begin
        if (seq_done) begin
          st_d        = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          ram_en_d    = 1'b1;
          ram_wr_rd_d = 1'b1;
          ram_addr_d  = seq_addr;
          ram_wdata_d = '0;
          init_busy_d = 1'b1;
          seq_step    = 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (hs) begin
          if (in_range) begin
            st_d        = ST_ACCESS;
            req_ready_d = 1'b0;
            ram_en_d    = 1'b1;
            ram_wr_rd_d = req_wr;
            ram_addr_d  = req_addr;
            ram_wdata_d = req_wdata;
          end else if (!req_wr) begin
            st_d        = ST_RESP;
            req_ready_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
          // out-of-range writes are dropped and the controller stays ready
        end
      end
      ST_ACCESS: begin
        if (ram_wr_rd_q) begin
          st_d        = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          st_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        st_d        = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_rdata;
        rsp_err_d   = 1'b0;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          st_d        = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= RST_STATE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wr_rd_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      st_q        <= st_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ram_en_q    <= ram_en_d;
      ram_wr_rd_q <= ram_wr_rd_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_en    = ram_en_q;
  assign ram_wr_rd = ram_wr_rd_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

`default_nettype wire
